// File: rtl/puf_sequencer.sv
// puf_sequencer: control sequencer for a ring-oscillator PUF measurement.
// For each of NBITS response bits it loads the LFSR, warms the ROs up,
// measures one or more reference windows, and shifts the resulting bit out.
// All strobes are registered and are a pure decode of the current state.
//
// Optional feature macro: PUF_SEQ_MAJORITY_VOTE_EN
//   defined   : each bit is the majority of NVOTES sampled comparator results
//   undefined : one sample per bit, resp_bit is the cmp_bit captured in LATCH
module puf_sequencer #(
   parameter int NBITS         = 256,
   parameter int WARMUP_CYCLES = 5,
   parameter int REF_W         = 8,
   parameter int WINDOW        = 2**REF_W-1,
   parameter int NVOTES        = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [REF_W-1:0]         refcount,
   input  logic                     cmp_bit,
   output logic                     done,
   output logic                     busy,
   output logic                     lfsrDV,
   output logic                     lfsrEN,
   output logic                     roEN,
   output logic                     countEN,
   output logic                     refEN,
   output logic                     srEN,
   output logic                     countReset,
   output logic                     resp_bit,
   output logic [$clog2(NBITS)-1:0] bit_idx
);

   localparam int                IW    = $clog2(NBITS);
   localparam logic [IW-1:0]     LASTB = IW'(NBITS-1);
   localparam logic [7:0]        WLAST = 8'(WARMUP_CYCLES-1);
   localparam logic [REF_W-1:0]  WIN   = REF_W'(WINDOW);

   // Reject illegal configurations at elaboration time
   if (NBITS < 2 || NBITS > 65536 || WARMUP_CYCLES < 1 || WARMUP_CYCLES > 255 ||
       NVOTES < 1 || NVOTES > 15 || (NVOTES % 2) == 0) begin : g_bad_params
      $error("puf_sequencer: parameter out of legal range");
   end

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      LOAD    = 4'd1,
      WARMUP  = 4'd2,
      MEASURE = 4'd3,
      LATCH   = 4'd4,
      RESTART = 4'd5,
      EMIT    = 4'd6,
      HOLD    = 4'd7
   } state_t;

   typedef struct packed {
      logic lfsr_dv;
      logic lfsr_en;
      logic ro_en;
      logic count_en;
      logic ref_en;
      logic sr_en;
      logic count_reset;
   } strobe_t;

   // Strobe pattern for each state; unknown encodings look like IDLE
   function automatic strobe_t decode(input state_t s);
      strobe_t d;
      d = '0;
      case (s)
         LOAD: begin
            d.lfsr_dv     = 1'b1;
            d.lfsr_en     = 1'b1;
            d.ro_en       = 1'b1;
            d.count_reset = 1'b1;
         end
         WARMUP, RESTART: begin
            d.ro_en       = 1'b1;
            d.count_reset = 1'b1;
         end
         MEASURE: begin
            d.ro_en    = 1'b1;
            d.count_en = 1'b1;
            d.ref_en   = 1'b1;
         end
         LATCH: d.count_en = 1'b1;
         EMIT: begin
            d.sr_en   = 1'b1;
            d.lfsr_en = 1'b1;
         end
         default: d.count_reset = 1'b1;
      endcase
      return d;
   endfunction

   state_t     state, nxt;
   strobe_t    strb;
   logic [7:0] wcnt;
   logic       last_vote;
   logic       last_bit;

`ifdef PUF_SEQ_MAJORITY_VOTE_EN
   localparam logic [3:0] VLAST = 4'(NVOTES-1);
   localparam logic [3:0] HALF  = 4'(NVOTES/2);
   logic [3:0] vcnt;
   logic [3:0] tally;
   logic [3:0] tally_nxt;

   assign tally_nxt = tally + {3'b000, cmp_bit};
   assign last_vote = (vcnt == VLAST);
`else
   assign last_vote = 1'b1;
`endif

   assign last_bit = (bit_idx == LASTB);

   // Next-state selection; start low aborts everywhere except EMIT/IDLE/HOLD
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (start) nxt = LOAD;
         LOAD:    nxt = start ? WARMUP : IDLE;
         WARMUP: begin
            if (!start)             nxt = IDLE;
            else if (wcnt == WLAST) nxt = MEASURE;
         end
         MEASURE: begin
            if (!start)                nxt = IDLE;
            else if (refcount == WIN)  nxt = LATCH;
         end
         LATCH: begin
            if (!start)         nxt = IDLE;
            else if (last_vote) nxt = EMIT;
            else                nxt = RESTART;
         end
         RESTART: nxt = start ? MEASURE : IDLE;
         EMIT:    nxt = last_bit ? HOLD : RESTART;
         HOLD:    if (!start) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // State, registered strobes/status, counters and response capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         strb     <= decode(IDLE);
         done     <= 1'b0;
         busy     <= 1'b0;
         resp_bit <= 1'b0;
         bit_idx  <= '0;
         wcnt     <= '0;
`ifdef PUF_SEQ_MAJORITY_VOTE_EN
         vcnt     <= '0;
         tally    <= '0;
`endif
      end else begin
         state <= nxt;
         strb  <= decode(nxt);
         done  <= (nxt == HOLD) && (state != HOLD);
         busy  <= (nxt != IDLE) && (nxt != HOLD);
         wcnt  <= (state == WARMUP) ? wcnt + 8'd1 : 8'd0;

         // bit_idx parks on the last bit in HOLD and clears on any IDLE entry
         if (nxt == IDLE)
            bit_idx <= '0;
         else if (state == EMIT && !last_bit)
            bit_idx <= bit_idx + IW'(1);

`ifdef PUF_SEQ_MAJORITY_VOTE_EN
         if (state == LATCH) begin
            tally <= tally_nxt;
            vcnt  <= vcnt + 4'd1;
            if (last_vote) resp_bit <= (tally_nxt > HALF);
         end else if (state == EMIT || state == IDLE || nxt == IDLE) begin
            tally <= '0;
            vcnt  <= '0;
         end
`else
         if (state == LATCH) resp_bit <= cmp_bit;
`endif
      end
   end

   assign lfsrDV     = strb.lfsr_dv;
   assign lfsrEN     = strb.lfsr_en;
   assign roEN       = strb.ro_en;
   assign countEN    = strb.count_en;
   assign refEN      = strb.ref_en;
   assign srEN       = strb.sr_en;
   assign countReset = strb.count_reset;

endmodule

// File: doc/puf_sequencer.md
PUF_SEQUENCER -- requirements
Module: puf_sequencer

Interface
REQ-001 Parameter NBITS, default 256; number of response bits per run; legal range 2..65536.
REQ-002 Parameter WARMUP_CYCLES, default 5; RO warm-up length in clocks; legal range 1..255.
REQ-003 Parameter REF_W, default 8; reference-counter width.
REQ-004 Parameter WINDOW, default 2**REF_W-1; refcount value that closes a sample window.
REQ-005 Parameter NVOTES, default 3; samples per response bit; odd, 1..15.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst_n  input  1  reset; asynchronous, active-low.
REQ-008 start  input  1  level request; held high for a whole run.
REQ-009 refcount  input  REF_W  reference-counter value.
REQ-010 cmp_bit  input  1  ring-oscillator comparator result.
REQ-011 done  output  1  one-cycle pulse when the run completes.
REQ-012 busy  output  1  high while a run is in progress.
REQ-013 lfsrDV, lfsrEN, roEN, countEN, refEN, srEN, countReset  outputs  1 each  submodule strobes.
REQ-014 resp_bit  output  1  voted response bit, valid while srEN=1.
REQ-015 bit_idx  output  clog2(NBITS)  index of the bit being measured.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD, WARMUP, MEASURE, LATCH, RESTART, EMIT and HOLD; strobes SHALL be decoded from the state alone.
REQ-017 IDLE: countReset=1, all other strobes 0; start=1 -> LOAD; bit and vote counters cleared.
REQ-018 LOAD (exactly 1 cycle): lfsrDV=1, lfsrEN=1, roEN=1, countReset=1 -> WARMUP.
REQ-019 WARMUP: roEN=1, countReset=1 for exactly WARMUP_CYCLES cycles -> MEASURE.
REQ-020 MEASURE: roEN=1, countEN=1, refEN=1, countReset=0; refcount==WINDOW -> LATCH.
REQ-021 LATCH (1 cycle): countEN=1, all else 0; SHALL add cmp_bit to the ones-tally and increment the sample count; last sample -> EMIT, otherwise -> RESTART.
REQ-022 RESTART (1 cycle): roEN=1, countReset=1 -> MEASURE.
REQ-023 EMIT (1 cycle): srEN=1, lfsrEN=1; resp_bit=1 iff ones-tally > NVOTES/2; tally and sample count cleared; bit_idx increments; bit_idx==NBITS-1 -> HOLD, otherwise -> RESTART.
REQ-024 done SHALL be registered and high only in the first cycle of HOLD.
REQ-025 HOLD: countReset=1, all else 0; start=0 -> IDLE.
REQ-026 If start=0 in LOAD, WARMUP, MEASURE, LATCH or RESTART, the next state SHALL be IDLE, with no done pulse and no srEN.
REQ-027 The abort rule SHALL NOT apply in EMIT, so a bit is never half-shifted.
REQ-028 busy SHALL be 1 in every state except IDLE and HOLD.
REQ-029 bit_idx SHALL stay at NBITS-1 in HOLD and clear on entry to IDLE.
REQ-030 An unreachable state encoding SHALL return to IDLE on the next clock.

Reset
REQ-031 rst_n low SHALL force IDLE immediately, with done=0, busy=0, countReset=1, all other strobes 0, resp_bit=0, bit_idx=0, and all counters 0.
REQ-032 Reset assertion mid-run SHALL discard the run; after release the block SHALL wait in IDLE for start=1.

Configuration
REQ-033 Macro PUF_SEQ_MAJORITY_VOTE_EN defined: NVOTES-sample majority voting per REQ-021/023.
REQ-034 Macro PUF_SEQ_MAJORITY_VOTE_EN undefined: NVOTES is ignored and treated as 1; no tally logic; LATCH always goes to EMIT; resp_bit = cmp_bit captured in LATCH.

Verification
REQ-035 NBITS=8, WARMUP_CYCLES=5, NVOTES=3, REF_W=8 with a free-running refcount model, start held high -> exactly 8 srEN pulses; done high for 1 cycle; busy falls with done.
REQ-036 cmp_bit samples 1,0,1 for bit 0 -> resp_bit=1 at EMIT; samples 0,0,1 -> resp_bit=0.
REQ-037 start dropped in the second MEASURE of bit 3 -> IDLE next cycle; no done; srEN count=3.
REQ-038 rst_n pulsed low during WARMUP -> outputs at reset values asynchronously; a new run after release completes normally.
REQ-039 Start to LOAD to MEASURE timing -> lfsrDV high exactly 1 cycle; MEASURE entered exactly WARMUP_CYCLES+1 cycles after LOAD.
REQ-040 Macro undefined, NBITS=4 -> 4 MEASURE windows total; resp_bit equals the cmp_bit captured in each LATCH.
